dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- MEM-stage controller that sequences every load/store leaving the EX/MEM register onto a word-only, variable-latency data-memory bus (req/ack).
- Sub-word stores (sb/sh) are done as read-modify-write. Load data is aligned and sign- or zero-extended.
- Misaligned addresses and bus timeouts are flagged.
- Drives StallM, which freezes PC/IF/ID/EX/MEM pipeline registers while an access is in flight.

Parameters:
- TIMEOUT, 255: max cycles a request waits for mem_ack before a bus error is raised.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MemToRegM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage; wins if both are set
- IsLbSbM  in  1  byte access
- IsLhShM  in  1  halfword access
- IsUnsignedM  in  1  zero-extend load (lbu/lhu)
- ALUOutM  in  32  effective byte address
- WriteDataM  in  32  store data; byte/half in low bits
- mem_rdata  in  32  read word, valid while mem_ack=1
- mem_ack  in  1  single-cycle completion pulse
- mem_req  out  1  request, held until ack
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  30  word address = ALUOutM[31:2]
- mem_wdata  out  32  write word
- StallM  out  1  freeze pipeline
- ReadDataM  out  32  extended load result
- AddrErrM  out  1  misaligned-access pulse
- BusErrM  out  1  timeout pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req, mem_we, StallM, AddrErrM, BusErrM = 0; ReadDataM, mem_wdata, mem_addr, counter = 0. Reset mid-access abandons the access with no write issued afterwards.
- States: IDLE, RD, RMW_RD, WR, DONE.
- mem_req=1 exactly in RD, RMW_RD and WR. mem_we=1 only in WR.
- StallM=1 in RD, RMW_RD, WR, and in IDLE when a valid aligned op is present (combinational). StallM=0 in DONE.
- IDLE, decode:
  - Misaligned = lw/sw with addr[1:0]≠0, or lh/sh with addr[0]≠0.
  - Misaligned: AddrErrM=1 this cycle, no stall, no bus access, state stays IDLE.
  - Aligned load or sw → RD (load) or WR (sw, mem_wdata=WriteDataM).
  - Aligned sb/sh → RMW_RD.
  - mem_addr is registered on the transition.
- RD on ack: capture the extended result into ReadDataM → DONE.
  - lb: byte at addr[1:0], little-endian (offset 0 = bits 7:0).
  - lh: half at addr[1].
  - Extension is sign unless IsUnsignedM.
- RMW_RD on ack: merge WriteDataM[7:0] (sb) or [15:0] (sh) into mem_rdata at the addressed lane → mem_wdata; next state WR.
- WR on ack → DONE.
- DONE: lasts exactly 1 cycle, StallM=0 so the pipeline advances; ReadDataM holds the result through this cycle; → IDLE.
- Timeout:
  - Counter clears on entry to each request state and increments each cycle without ack.
  - When it reaches TIMEOUT → DONE with BusErrM=1 for that DONE cycle and ReadDataM=0.
  - A timed-out RMW_RD skips WR (no write).
- mem_ack outside request states is ignored. Ack in the first request cycle is legal.
- Latency (ack in first request cycle):
  - load or sw: 2 stall cycles, then DONE.
  - sb/sh: 3 stall cycles, then DONE.
- Back-to-back ops: the next instruction is evaluated in the IDLE cycle following DONE.
- No op (MemToRegM=MemWriteM=0): stay IDLE, StallM=0.

Test Plan:
- lw, ALUOutM=0x100, ack on first RD cycle with rdata=0xDEADBEEF → mem_addr=0x40; StallM high 2 cycles; DONE with ReadDataM=0xDEADBEEF.
- lb, addr=0x103, rdata=0x80123456 → ReadDataM=0xFFFFFF80. Same with lbu → 0x00000080.
- sb, addr=0x202, WriteDataM=0xAB, RMW read returns 0x11223344 → WR cycle drives mem_we=1, mem_wdata=0x11AB3344; StallM high 3 cycles.
- lh at addr=0x301 → AddrErrM=1 for one cycle, mem_req never asserts, StallM=0.
- lw with mem_ack never asserted, TIMEOUT=4 → DONE after 4 RD cycles; BusErrM=1; ReadDataM=0. Repeat with sh → no WR request.
- Pull rst low in WR mid-sh → mem_req=0, StallM=0 immediately. After release: IDLE, no spurious write.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-only req/ack data bus.
// Sub-word stores use read-modify-write; loads are lane-aligned and extended.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic        IsLbSbM,
  input  logic        IsLhShM,
  input  logic        IsUnsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        AddrErrM,
  output logic        BusErrM
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_vld, misalign, go, timeout;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_val, wrep, merged;
  logic [3:0]       be;

  // EX/MEM inputs stay frozen by StallM for the whole access, so they are used live.
  assign op_vld   = MemToRegM | MemWriteM;
  assign misalign = IsLbSbM ? 1'b0 : (IsLhShM ? ALUOutM[0] : |ALUOutM[1:0]);
  assign go       = rst & (state == IDLE) & op_vld & ~misalign;
  assign AddrErrM = rst & (state == IDLE) & op_vld & misalign;

  assign mem_req = (state == RD) | (state == RMW_RD) | (state == WR);
  assign mem_we  = (state == WR);
  assign StallM  = mem_req | go;
  // ack on the last allowed cycle still counts as a completion
  assign timeout = mem_req & ~mem_ack & (cnt == CNT_W'(TIMEOUT - 1));

  assign ld_b = mem_rdata[{ALUOutM[1:0], 3'b000} +: 8];
  assign ld_h = ALUOutM[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    if (IsLbSbM)      ld_val = {{24{ld_b[7] & ~IsUnsignedM}}, ld_b};
    else if (IsLhShM) ld_val = {{16{ld_h[15] & ~IsUnsignedM}}, ld_h};
    else              ld_val = mem_rdata;
  end

  // Store data replicated to every lane; byte enables pick which lanes replace the read word.
  always_comb begin
    be   = IsLbSbM ? (4'b0001 << ALUOutM[1:0]) : (ALUOutM[1] ? 4'b1100 : 4'b0011);
    wrep = IsLbSbM ? {4{WriteDataM[7:0]}} : {2{WriteDataM[15:0]}};
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BusErrM <= 1'b0;
          if (go) begin
            mem_addr <= ALUOutM[31:2];
            cnt      <= '0;
            if (!MemWriteM) state <= RD;
            else if (IsLbSbM | IsLhShM) state <= RMW_RD;
            else begin
              state     <= WR;
              mem_wdata <= WriteDataM;
            end
          end
        end
        RD, RMW_RD, WR: begin
          if (mem_ack) begin
            cnt <= '0;
            if (state == RD) begin
              ReadDataM <= ld_val;
              state     <= DONE;
            end else if (state == RMW_RD) begin
              mem_wdata <= merged;
              state     <= WR;
            end else begin
              state <= DONE;
            end
          end else if (timeout) begin
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          BusErrM <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios then random ops against a word-memory model.
module tb_dmem_access_ctrl;

  localparam int TO    = 4;
  localparam int NEVER = 99;

  logic        clk, rst;
  logic        MemToRegM, MemWriteM, IsLbSbM, IsLhShM, IsUnsignedM;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, StallM, AddrErrM, BusErrM;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, ReadDataM;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] dev_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .IsLbSbM(IsLbSbM), .IsLhShM(IsLhShM),
    .IsUnsignedM(IsUnsignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .StallM(StallM), .ReadDataM(ReadDataM), .AddrErrM(AddrErrM), .BusErrM(BusErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [29:0] w);
    return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int sz,
                                             input bit uns, input logic [1:0] off);
    logic [31:0] v;
    if (sz == 0) return word;
    if (sz == 2) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = (word >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                              input int sz, input logic [1:0] off);
    int sh;
    logic [31:0] mask;
    if (sz == 0) return wd;
    sh   = (sz == 2) ? 8 * off : 16 * off[1];
    mask = ((sz == 2) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic preload(input logic [29:0] w, input logic [31:0] v);
    dev_mem[w] = v;
    ref_mem[w] = v;
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends the op.
  // sz: 0 word, 1 half, 2 byte. d1/d2: wait cycles before ack on read/write phases.
  task automatic do_op(input bit ld, input bit st, input int sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input int d1, input int d2,
                       output logic [31:0] rd_obs, output logic [31:0] wdata_obs);
    bit is_op, mis, act, ldop, rmw, to1, to2, bus_e, wr_e, we_e;
    bit req_seen, we_seen, busy;
    int stall_e, stalls, run, cyc, wr_n, dl;
    logic [29:0] w;
    logic [31:0] old, exp_rd;

    MemToRegM = ld; MemWriteM = st; IsLbSbM = (sz == 2); IsLhShM = (sz == 1);
    IsUnsignedM = uns; ALUOutM = a; WriteDataM = wd;

    is_op = ld | st;
    mis   = (sz == 0) ? (a[1:0] != 2'b00) : (sz == 1) ? a[0] : 1'b0;
    act   = is_op & !mis;
    ldop  = ld & !st;
    rmw   = st & (sz != 0);
    to1   = (d1 >= TO);
    to2   = (d2 >= TO);
    if (!act)      stall_e = 0;
    else if (ldop) stall_e = 1 + (to1 ? TO : d1 + 1);
    else if (!rmw) stall_e = 1 + (to2 ? TO : d2 + 1);
    else           stall_e = 1 + (to1 ? TO : (d1 + 1 + (to2 ? TO : d2 + 1)));
    bus_e = act & (ldop ? to1 : (!rmw ? to2 : (to1 | to2)));
    wr_e  = act & st & !bus_e;
    we_e  = act & st & !(rmw & to1);
    w      = a[31:2];
    old    = ref_rd(w);
    exp_rd = bus_e ? 32'h0 : model_load(old, sz, uns, a[1:0]);
    if (wr_e) ref_mem[w] = model_store(old, wd, sz, a[1:0]);

    req_seen = 0; we_seen = 0; busy = 1;
    stalls = 0; run = 0; cyc = 0; wr_n = 0;
    wdata_obs = 32'h0;
    while (busy) begin
      @(negedge clk);
      if (cyc == 0) chk("addr_err", 32'(AddrErrM), 32'(is_op & mis));
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (run == 0) chk("mem_addr", 32'(mem_addr), 32'(w));
        req_seen = 1;
        if (mem_we) we_seen = 1;
        dl = mem_we ? d2 : d1;
        if (run == dl) begin
          mem_ack = 1'b1;
          run = 0;
          if (mem_we) begin
            dev_mem[mem_addr] = mem_wdata;
            wdata_obs = mem_wdata;
            wr_n++;
          end else begin
            mem_rdata = dev_rd(mem_addr);
          end
        end else begin
          run++;
        end
      end else begin
        run = 0;
      end
      if (StallM) stalls++;
      else busy = 0;
      cyc++;
      if (cyc > 100) begin
        chk("op_bound", 32'(cyc), 32'(stall_e + 1));
        busy = 0;
      end
    end
    rd_obs = ReadDataM;
    chk("stall_cycles", 32'(stalls), 32'(stall_e));
    chk("bus_err", 32'(BusErrM), 32'(bus_e));
    chk("req_seen", 32'(req_seen), 32'(act));
    chk("we_seen", 32'(we_seen), 32'(we_e));
    chk("writes", 32'(wr_n), 32'(wr_e));
    if (act && ldop) chk("read_data", ReadDataM, exp_rd);
    if (act && st) chk("mem_word", dev_rd(w), ref_rd(w));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, wdo;
    bit ld, st, uns, hit;
    int op, sz, d1, d2, nreq;
    logic [31:0] a;

    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    MemToRegM = 0; MemWriteM = 0; IsLbSbM = 0; IsLhShM = 0; IsUnsignedM = 0;
    ALUOutM = '0; WriteDataM = '0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_read_data", ReadDataM, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_bus_err", 32'(BusErrM), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // lw with immediate ack
    preload(30'h40, 32'hDEADBEEF);
    do_op(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, rd, wdo);
    chk("lw_value", rd, 32'hDEADBEEF);

    // lb / lbu at top byte lane
    preload(30'h40, 32'h80123456);
    do_op(1, 0, 2, 0, 32'h103, 32'h0, 0, 0, rd, wdo);
    chk("lb_value", rd, 32'hFFFFFF80);
    do_op(1, 0, 2, 1, 32'h103, 32'h0, 1, 0, rd, wdo);
    chk("lbu_value", rd, 32'h00000080);

    // sb read-modify-write
    preload(30'h80, 32'h11223344);
    do_op(0, 1, 2, 0, 32'h202, 32'h000000AB, 0, 0, rd, wdo);
    chk("sb_wdata", wdo, 32'h11AB3344);

    // misaligned lh
    do_op(1, 0, 1, 0, 32'h301, 32'h0, 0, 0, rd, wdo);

    // timeouts: lw never acked, sh with RMW read never acked
    do_op(1, 0, 0, 0, 32'h104, 32'h0, NEVER, 0, rd, wdo);
    chk("lw_timeout_value", rd, 32'h0);
    do_op(0, 1, 1, 0, 32'h206, 32'h1234, NEVER, 0, rd, wdo);

    // reset in the WR phase of an sh
    preload(30'h50, 32'hCAFEF00D);
    MemWriteM = 1; MemToRegM = 0; IsLhShM = 1; IsLbSbM = 0; IsUnsignedM = 0;
    ALUOutM = 32'h142; WriteDataM = 32'h0000BEEF;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && mem_we) hit = 1;
      else if (mem_req) begin
        mem_ack = 1'b1;
        mem_rdata = dev_rd(mem_addr);
      end
    end
    chk("rst_reach_wr", 32'(hit), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_stall", 32'(StallM), 32'h0);
    chk("rst_mid_we", 32'(mem_we), 32'h0);
    MemWriteM = 0; IsLhShM = 0; ALUOutM = '0; WriteDataM = '0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nreq = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    chk("rst_no_req", 32'(nreq), 32'h0);
    chk("rst_mem_intact", dev_rd(30'h50), 32'hCAFEF00D);
    @(posedge clk);
    #1;

    // random ops
    for (int k = 0; k < 80; k++) begin
      op  = int'($urandom_range(0, 9));
      ld  = (op >= 1 && op <= 4) || op == 8 || op == 9;
      st  = (op >= 5 && op <= 8);
      sz  = int'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a   = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 0) a[1:0] = 2'b00;
        else if (sz == 1) a[0] = 1'b0;
      end
      d1 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      d2 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      do_op(ld, st, sz, uns, a, $urandom, d1, d2, rd, wdo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
